// File: rtl/vga_pkg.sv
// Shared VGA render definitions: render command layout, DO_RENDER marker,
// render_queue register map and default queue length.
package vga_pkg;

  typedef struct packed {
    logic [7:0]  magic;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } render_cmd_t;

  localparam logic [7:0] MAGIC_DO_RENDER = 8'hFF;

  // Register map
  localparam logic [2:0] ADDR_MAGIC_FLAGS = 3'd0;
  localparam logic [2:0] ADDR_X           = 3'd1;
  localparam logic [2:0] ADDR_Y           = 3'd2;
  localparam logic [2:0] ADDR_PUSH        = 3'd3;
  localparam logic [2:0] ADDR_STATUS      = 3'd4;
  localparam logic [2:0] ADDR_CLR_OVF     = 3'd5;

  localparam int unsigned RENDER_Q_LEN = 25;

  // Head value presented when nothing is visible to the display.
  localparam render_cmd_t DO_RENDER_CMD = '{magic: MAGIC_DO_RENDER, x: 16'h0, y: 16'h0,
                                            flags: 8'h0};

endpackage

// File: rtl/render_queue_mem.sv
// Command storage for render_queue.
// DEPTH x 48-bit array, one synchronous write port and one asynchronous
// read port so the head entry is available show-ahead.
// Ports: clk50, we/waddr/wdata (write), raddr/rdata (combinational read).
module render_queue_mem
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = RENDER_Q_LEN,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk50,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  render_cmd_t      wdata,
  input  logic [CNT_W-1:0] raddr,
  output render_cmd_t      rdata
);

  // Contents are not reset; the pointers decide what is valid.
  render_cmd_t mem_q [DEPTH];

  always_ff @(posedge clk50) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/render_queue.sv
// Sprite-command FIFO between the HPS Avalon-MM slave and vga_display.
// Software stages a 48-bit command through 16-bit registers and pushes it;
// the display reads the head show-ahead and pops one entry per fetch.
// An empty (or unpublished) queue presents the DO_RENDER marker.
// Ports: clk50, reset (sync, active-high), Avalon chipselect/write/read/
// address/writedata/readdata, render_queue_dout (head), render_queue_pop_front.
// Build option: RENDER_QUEUE_FRAME_COMMIT_EN - entries only become visible
// once a DO_RENDER (magic 0xFF) entry is pushed behind them.
module render_queue
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = RENDER_Q_LEN,
  parameter int unsigned CNT_W = 5
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       stg_magic_q, stg_flags_q;
  logic [15:0]      stg_x_q, stg_y_q;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] stored_q, stored_d;  // all entries held
  logic [CNT_W-1:0] vis_q, vis_d;        // entries the display may consume
  logic             overflow_q, overflow_d;
  logic [15:0]      readdata_q;

  render_cmd_t staged, head;
  logic        reg_wr, push_req, push_ok, pop_ok, full, empty;
  logic [4:0]  count5;
  logic [15:0] status;

  assign staged   = '{magic: stg_magic_q, x: stg_x_q, y: stg_y_q, flags: stg_flags_q};
  assign reg_wr   = chipselect & write;
  assign push_req = reg_wr && (address == ADDR_PUSH);
  assign full     = (stored_q == FULL_CNT);
  assign empty    = (vis_q == '0);
  assign pop_ok   = render_queue_pop_front && !empty;
  // A same-cycle pop frees the slot a full queue needs.
  assign push_ok  = push_req && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end
    stored_d = stored_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    overflow_d = overflow_q;
    if (reg_wr && (address == ADDR_CLR_OVF)) begin
      overflow_d = 1'b0;
    end else if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

`ifdef RENDER_QUEUE_FRAME_COMMIT_EN
  logic [CNT_W-1:0] pub_ptr_q, pub_ptr_d;
  logic             publish;

  assign publish = push_ok && (stg_magic_q == MAGIC_DO_RENDER);

  always_comb begin
    pub_ptr_d = pub_ptr_q;
    vis_d     = vis_q;
    if (publish) begin
      // Everything up to the post-push write pointer is now visible.
      pub_ptr_d = wr_ptr_d;
      vis_d     = stored_d;
    end else if (pop_ok) begin
      vis_d = (rd_ptr_d == pub_ptr_q) ? '0 : vis_q - 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      pub_ptr_q <= '0;
    end else begin
      pub_ptr_q <= pub_ptr_d;
    end
  end
`else
  // Publish pointer follows the write pointer, so visible == stored.
  assign vis_d = stored_d;
`endif

  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stored_q    <= '0;
      vis_q       <= '0;
      overflow_q  <= 1'b0;
      stg_magic_q <= '0;
      stg_flags_q <= '0;
      stg_x_q     <= '0;
      stg_y_q     <= '0;
      readdata_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stored_q   <= stored_d;
      vis_q      <= vis_d;
      overflow_q <= overflow_d;
      if (reg_wr && (address == ADDR_MAGIC_FLAGS)) begin
        stg_magic_q <= writedata[15:8];
        stg_flags_q <= writedata[7:0];
      end
      if (reg_wr && (address == ADDR_X)) stg_x_q <= writedata;
      if (reg_wr && (address == ADDR_Y)) stg_y_q <= writedata;
      if (chipselect && read) begin
        readdata_q <= (address == ADDR_STATUS) ? status : 16'h0;
      end
    end
  end

  assign count5 = 5'(vis_q);
  assign status = {overflow_q, full, empty, 8'b0, count5};

  render_queue_mem #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_mem (
    .clk50 (clk50),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (staged),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign readdata          = readdata_q;
  assign render_queue_dout = empty ? DO_RENDER_CMD : head;

endmodule

// File: tb/tb_render_queue.sv
module tb_render_queue;

  localparam int DEPTH = 25;
  localparam logic [47:0] MARKER = 48'hFF00_0000_0000;
`ifdef RENDER_QUEUE_FRAME_COMMIT_EN
  localparam bit COMMIT = 1'b1;
`else
  localparam bit COMMIT = 1'b0;
`endif

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0, pop = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] readdata;
  logic [47:0] dout;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored commands, number visible to display.
  logic [47:0] mq[$];
  int          vis = 0;
  bit          ovf = 1'b0;
  logic [7:0]  stg_m = '0, stg_f = '0;
  logic [15:0] stg_x = '0, stg_y = '0;

  render_queue dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (cs),
    .write                  (wr),
    .read                   (rd),
    .address                (addr),
    .writedata              (wdata),
    .readdata               (readdata),
    .render_queue_dout      (dout),
    .render_queue_pop_front (pop)
  );

  always #10 clk50 = ~clk50;

  task automatic check(string tag, logic [47:0] obs, logic [47:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    logic [4:0] c;
    c = 5'(vis);
    return {ovf, (mq.size() == DEPTH), (vis == 0), 8'b0, c};
  endfunction

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick();
    bit          rd_valid, push, full, pop_ok, push_ok;
    logic [15:0] exp_rd;
    rd_valid = reset || (cs && rd);
    exp_rd   = (!reset && addr == 3'd4) ? model_status() : 16'h0;
    if (reset) begin
      mq.delete();
      vis = 0; ovf = 0; stg_m = '0; stg_f = '0; stg_x = '0; stg_y = '0;
    end else begin
      push    = cs && wr && addr == 3'd3;
      full    = mq.size() == DEPTH;
      pop_ok  = pop && vis > 0;
      push_ok = push && (!full || pop_ok);
      if (pop_ok) begin
        void'(mq.pop_front());
        vis--;
      end
      if (push_ok) begin
        mq.push_back({stg_m, stg_x, stg_y, stg_f});
        if (!COMMIT || stg_m == 8'hFF) vis = mq.size();
      end
      if (cs && wr && addr == 3'd5) ovf = 0;
      else if (push && !push_ok) ovf = 1;
      if (cs && wr) begin
        case (addr)
          3'd0: begin stg_m = wdata[15:8]; stg_f = wdata[7:0]; end
          3'd1: stg_x = wdata;
          3'd2: stg_y = wdata;
          default: ;
        endcase
      end
    end
    @(posedge clk50);
    #1;
    check("dout", dout, (vis > 0) ? mq[0] : MARKER);
    if (rd_valid) check("readdata", {32'h0, readdata}, {32'h0, exp_rd});
  endtask

  task automatic idle_inputs();
    cs = 0; wr = 0; rd = 0; pop = 0; addr = '0; wdata = '0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    cs = 1; wr = 1; addr = a; wdata = d;
    tick();
    idle_inputs();
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cs = 1; rd = 1; addr = a;
    tick();
    idle_inputs();
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      pop = 1;
      tick();
    end
    pop = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    logic [15:0] r;

    // Reset state
    do_reset();
    check("reset_dout", dout, MARKER);
    rd_reg(3'd4);
    check("reset_status", {32'h0, readdata}, 48'h2000);

    // First command
    wr_reg(3'd0, 16'h0201);
    wr_reg(3'd1, 16'd100);
    wr_reg(3'd2, 16'd200);
    wr_reg(3'd3, 16'h0);
    if (COMMIT) begin
      wr_reg(3'd0, 16'hFF00);
      wr_reg(3'd3, 16'h0);
    end
    check("first_cmd", dout, {8'h02, 16'd100, 16'd200, 8'h01});
    rd_reg(3'd4);
    check("first_count", {32'h0, readdata}, COMMIT ? 48'h0002 : 48'h0001);

    // Fill past capacity
    do_reset();
    for (int i = 0; i < 26; i++) begin
      r = 16'($urandom);
      if (i == 24) r[15:8] = 8'hFF;
      else if (r[15:8] == 8'hFF) r[15:8] = 8'h10;
      wr_reg(3'd0, r);
      wr_reg(3'd1, 16'($urandom));
      wr_reg(3'd2, 16'($urandom));
      wr_reg(3'd3, 16'h0);
    end
    rd_reg(3'd4);
    check("full_ovf_status", {32'h0, readdata}, 48'hC019);
    wr_reg(3'd5, 16'h0);
    rd_reg(3'd4);
    check("ovf_cleared", {32'h0, readdata}, 48'h4019);

    // Full queue: push and pop together, new entry lands in wrapped slot
    wr_reg(3'd0, 16'hFF5A);
    wr_reg(3'd1, 16'h1234);
    cs = 1; wr = 1; addr = 3'd3; pop = 1;
    tick();
    idle_inputs();
    rd_reg(3'd4);
    check("full_push_pop", {32'h0, readdata}, 48'h4019);
    pop_n(24);
    check("wrapped_entry", dout[47:24], 24'hFF1234);
    pop_n(1);

    // Pops on empty queue are ignored
    pop_n(3);
    check("empty_dout", dout, MARKER);
    rd_reg(3'd4);
    check("empty_status", {32'h0, readdata}, 48'h2000);

`ifdef RENDER_QUEUE_FRAME_COMMIT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_reg(3'd0, 16'h0100 | 16'(i));
      wr_reg(3'd3, 16'h0);
    end
    check("unpublished_dout", dout, MARKER);
    rd_reg(3'd4);
    check("unpublished_status", {32'h0, readdata}, 48'h2000);
    wr_reg(3'd0, 16'hFF00);
    wr_reg(3'd3, 16'h0);
    rd_reg(3'd4);
    check("published_status", {32'h0, readdata}, 48'h0004);
    check("published_head", dout[47:40], 8'h01);
`endif

    // Random traffic against the model, with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      reset = (i == 300);
      cs    = ($urandom_range(7) != 0);
      addr  = 3'($urandom_range(7));
      if ($urandom_range(1) == 0) addr = 3'd3;
      wr    = ($urandom_range(2) != 0);
      rd    = ($urandom_range(1) == 0);
      wdata = 16'($urandom);
      if (addr == 3'd0 && $urandom_range(3) == 0) wdata[15:8] = 8'hFF;
      pop   = ($urandom_range(2) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
    rd_reg(3'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
